poets_debug_sysclk_bridge: RTL and testbench

//  System-clock half of the multi-core JTAG debug slave; successor to the single-core sysclk decoder.

---
 rtl/poets_debug_pkg.sv | 44 ++++
 rtl/poets_debug_bit_sync.sv | 30 +++
 rtl/poets_debug_sysclk_bridge.sv | 138 +++++++++++++
 tb/tb_poets_debug_sysclk_bridge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poets_debug_pkg.sv
// Shared types for the debug bridge: encoded debug actions, virtual-IR codes and the command decoder.
// The decoder is pure combinational; the bridge registers its result.
package poets_debug_pkg;

  typedef enum logic [3:0] {
    ACT_NONE       = 4'd0,
    OCIMEM_A       = 4'd1,
    NOACT_OCIMEM_A = 4'd2,
    OCIMEM_B       = 4'd3,
    BREAK_A        = 4'd4,
    BREAK_B        = 4'd5,
    BREAK_C        = 4'd6,
    NOACT_BREAK_A  = 4'd7,
    NOACT_BREAK_B  = 4'd8,
    NOACT_BREAK_C  = 4'd9,
    TRACECTRL      = 4'd10
  } act_e;

  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE  = 2'b01;
  localparam logic [1:0] IR_BREAK  = 2'b10;
  localparam logic [1:0] IR_TRCCTL = 2'b11;

  // t is the top two command bits, b the bit just below them
  function automatic act_e decode_act(input logic [1:0] ir, input logic [1:0] t, input logic b);
    act_e a;
    a = ACT_NONE;
    case (ir)
      IR_OCIMEM: a = t[1] ? OCIMEM_B : (t[0] ? OCIMEM_A : NOACT_OCIMEM_A);
      IR_TRACE:  a = ACT_NONE;
      IR_BREAK: begin
        case (t)
          2'b00:   a = b ? BREAK_A : NOACT_BREAK_A;
          2'b01:   a = b ? BREAK_B : NOACT_BREAK_B;
          2'b10:   a = b ? BREAK_C : NOACT_BREAK_C;
          default: a = ACT_NONE;
        endcase
      end
      default:   a = b ? TRACECTRL : ACT_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/poets_debug_bit_sync.sv
// Multi-flop synchroniser for one asynchronous level; STAGES clk of latency, no backpressure.
// All stages reset to RESET_VAL so a level already at that value at reset release produces no edge.
module poets_debug_bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/poets_debug_sysclk_bridge.sv
// Sysclk half of the JTAG debug slave: syncs TCK update strobes, captures/decodes the command, routes it to a channel.
// SYNC_STAGES+2 clk from vs_udr rise to act_valid; updates arriving while an action is in flight are dropped and counted.
module poets_debug_sysclk_bridge
  import poets_debug_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [SR_W-1:0]   sr,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] act_valid,
  output act_e              act_code,
  input  logic [NUM_CH-1:0] act_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);

  logic udr_s, uir_s;
  logic udr_hist_q, udr_hist_d, uir_hist_q, uir_hist_d;
  logic udr_edge, uir_edge, ch_bad, accept, udr_drop, ovr_evt;

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SR_W-1:0]   jdo_q, jdo_d;
  logic [1:0]        ir_q, ir_d;
  logic              cap_q, cap_d;
  logic [NUM_CH-1:0] vld_q, vld_d;
  act_e              code_q, code_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;

  poets_debug_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_udr (
    .clk(clk), .reset(reset), .d(vs_udr), .q(udr_s)
  );

  poets_debug_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_uir (
    .clk(clk), .reset(reset), .d(vs_uir), .q(uir_s)
  );

  always_comb begin
    udr_hist_d = udr_s;
    uir_hist_d = uir_s;
    ch_d       = ch_q;
    jdo_d      = jdo_q;
    ir_d       = ir_q;
    vld_d      = vld_q;
    code_d     = code_q;
    ovr_d      = ovr_q;
    issued_d   = issued_q;
    ovr_cnt_d  = ovr_cnt_q;

    udr_edge = udr_s & ~udr_hist_q;
    uir_edge = uir_s & ~uir_hist_q;
    ch_bad   = uir_edge & ({1'b0, ch_sel} >= (CH_W+1)'(NUM_CH));
    accept   = |(vld_q & act_ready);
    // Busy spans the capture->decode cycle and any unaccepted pending action
    udr_drop = udr_edge & (cap_q | ((|vld_q) & ~accept));
    ovr_evt  = udr_drop | ch_bad;
    cap_d    = udr_edge & ~udr_drop;

    if (uir_edge && !ch_bad) ch_d = ch_sel;

    if (cap_d) begin
      jdo_d = sr;
      ir_d  = ir_in[1:0];
    end

    if (accept) begin
      vld_d    = '0;
      issued_d = issued_q + CNT_W'(1);
    end

    if (cap_q) begin
      code_d = decode_act(ir_q, jdo_q[SR_W-1 -: 2], jdo_q[SR_W-3]);
      if (code_d != ACT_NONE) vld_d = NUM_CH'(1) << ch_q;
    end

    if (ovr_evt) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end

    if (clr_overrun) begin
      ovr_cnt_d = ovr_evt ? CNT_W'(1) : '0;
    end else if (ovr_evt && !(&ovr_cnt_q)) begin
      ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_hist_q <= 1'b1;
      uir_hist_q <= 1'b1;
      ch_q       <= '0;
      jdo_q      <= '0;
      ir_q       <= '0;
      cap_q      <= 1'b0;
      vld_q      <= '0;
      code_q     <= ACT_NONE;
      ovr_q      <= 1'b0;
      issued_q   <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      udr_hist_q <= udr_hist_d;
      uir_hist_q <= uir_hist_d;
      ch_q       <= ch_d;
      jdo_q      <= jdo_d;
      ir_q       <= ir_d;
      cap_q      <= cap_d;
      vld_q      <= vld_d;
      code_q     <= code_d;
      ovr_q      <= ovr_d;
      issued_q   <= issued_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign jdo         = jdo_q;
  assign act_valid   = vld_q;
  assign act_code    = code_q;
  assign overrun     = ovr_q;
  assign issued_cnt  = issued_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_poets_debug_sysclk_bridge.sv
// Bench for poets_debug_sysclk_bridge: decode table, directed handshake/overrun/reset sequences, random scoreboard.
// A second NUM_CH=5 instance shares the stimulus so an out-of-range channel select can be exercised.
module tb_poets_debug_sysclk_bridge;
  import poets_debug_pkg::*;

  localparam int SYNC = 2;
  localparam int NRND = 40;

  logic        clk = 1'b0;
  logic        reset, vs_udr, vs_uir, clr_overrun;
  logic [1:0]  ir_in;
  logic [1:0]  ch_sel;
  logic [2:0]  ch_sel5;
  logic [37:0] sr;
  logic [37:0] jdo, jdo5;
  logic [3:0]  act_valid, act_ready;
  logic [4:0]  act_valid5, act_ready5;
  logic [3:0]  act_code, act_code5;
  logic        overrun, overrun5;
  logic [15:0] issued_cnt, overrun_cnt, issued5, ovr_cnt5;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  assign act_ready5 = {1'b0, act_ready};

  poets_debug_sysclk_bridge u_dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in),
    .ch_sel(ch_sel), .sr(sr), .jdo(jdo), .act_valid(act_valid), .act_code(act_code),
    .act_ready(act_ready), .overrun(overrun), .clr_overrun(clr_overrun),
    .issued_cnt(issued_cnt), .overrun_cnt(overrun_cnt)
  );

  poets_debug_sysclk_bridge #(.NUM_CH(5)) u_dut5 (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in),
    .ch_sel(ch_sel5), .sr(sr), .jdo(jdo5), .act_valid(act_valid5), .act_code(act_code5),
    .act_ready(act_ready5), .overrun(overrun5), .clr_overrun(clr_overrun),
    .issued_cnt(issued5), .overrun_cnt(ovr_cnt5)
  );

  typedef struct {
    logic [1:0] ir;
    logic [2:0] top;   // {T, b}
    logic [3:0] code;
    logic       vld;
  } vec_t;

  typedef struct {
    logic [3:0]  code;
    logic [37:0] word;
    logic [3:0]  vld;
  } txn_t;

  vec_t vecs[12];
  txn_t sent[$];
  txn_t deliv[$];
  logic mon_en   = 1'b0;
  logic gen_done = 1'b0;

  always @(negedge clk) begin
    if (mon_en && ((act_valid & act_ready) != 4'b0))
      deliv.push_back('{act_code, jdo, act_valid});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [37:0] rand_sr(input logic [2:0] top);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {top, r[34:0]};
  endfunction

  // Action code straight from the command rules, as plain arithmetic on the code numbering
  function automatic logic [3:0] model_code(input logic [1:0] ir, input logic [2:0] top);
    int t;
    t = int'(top[2:1]);
    case (ir)
      2'b00:   return (t >= 2) ? 4'd3 : ((t == 1) ? 4'd1 : 4'd2);
      2'b10:   return (t == 3) ? 4'd0 : (top[0] ? 4'(4 + t) : 4'(7 + t));
      2'b11:   return top[0] ? 4'd10 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  task automatic pulse_uir(input logic [2:0] sel5);
    ch_sel5 = sel5;
    ch_sel  = (sel5 < 3'd4) ? sel5[1:0] : ch_sel;
    vs_uir  = 1'b1;
    tick(2);
    vs_uir = 1'b0;
    tick(4);
  endtask

  // One update with ready held low, then accept on channel ch if an action is expected
  task automatic run_update(input string name, input logic [1:0] ir, input logic [2:0] top,
                            input logic exp_vld, input logic [3:0] exp_code, input int ch);
    logic        seen;
    logic [15:0] prev;
    logic [37:0] w;
    seen = 1'b0;
    prev = issued_cnt;
    w = rand_sr(top);
    sr = w;
    ir_in = ir;
    act_ready = 4'b0;
    vs_udr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 2) vs_udr = 1'b0;
      if (act_valid != 4'b0) seen = 1'b1;
    end
    check({name, " jdo"}, jdo, w);
    if (exp_vld) begin
      check({name, " valid"}, act_valid, 4'(1 << ch));
      check({name, " code"}, act_code, exp_code);
      act_ready = 4'(1 << ch);
      tick(1);
      act_ready = 4'b0;
      check({name, " drop"}, act_valid, 4'b0);
      check({name, " issued"}, issued_cnt, prev + 16'd1);
    end else begin
      check({name, " no valid"}, seen, 1'b0);
      check({name, " issued"}, issued_cnt, prev);
    end
  endtask

  initial begin
    int          lat, rch, dropped, idx;
    logic [3:0]  v, c;
    logic [37:0] j, w3;
    logic        flag;

    vecs[0]  = '{2'b00, 3'b000, NOACT_OCIMEM_A, 1'b1};
    vecs[1]  = '{2'b00, 3'b010, OCIMEM_A,       1'b1};
    vecs[2]  = '{2'b00, 3'b101, OCIMEM_B,       1'b1};
    vecs[3]  = '{2'b01, 3'b111, ACT_NONE,       1'b0};
    vecs[4]  = '{2'b10, 3'b001, BREAK_A,        1'b1};
    vecs[5]  = '{2'b10, 3'b000, NOACT_BREAK_A,  1'b1};
    vecs[6]  = '{2'b10, 3'b011, BREAK_B,        1'b1};
    vecs[7]  = '{2'b10, 3'b010, NOACT_BREAK_B,  1'b1};
    vecs[8]  = '{2'b10, 3'b101, BREAK_C,        1'b1};
    vecs[9]  = '{2'b10, 3'b111, ACT_NONE,       1'b0};
    vecs[10] = '{2'b11, 3'b001, TRACECTRL,      1'b1};
    vecs[11] = '{2'b11, 3'b110, ACT_NONE,       1'b0};

    // Reset with both strobes already high: no edge may be seen afterwards
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b1; clr_overrun = 1'b0;
    ir_in = 2'b00; ch_sel = 2'd0; ch_sel5 = 3'd0; sr = '1; act_ready = 4'b0;
    tick(3);
    reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (act_valid != 4'b0) flag = 1'b1;
    end
    check("reset no valid", flag, 1'b0);
    check("reset jdo", jdo, 38'd0);
    check("reset code", act_code, ACT_NONE);
    check("reset overrun", overrun, 1'b0);
    check("reset issued", issued_cnt, 16'd0);
    check("reset ovr_cnt", overrun_cnt, 16'd0);
    vs_udr = 1'b0; vs_uir = 1'b0;
    tick(4);

    // Channel 2, OCIMEM_A with ready already high: latency and single-cycle accept
    pulse_uir(3'd2);
    ir_in = 2'b00;
    j = rand_sr(3'b010);
    sr = j;
    act_ready = 4'b0100;
    lat = 0; v = '0; c = '0; w3 = '0;
    vs_udr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 2) vs_udr = 1'b0;
      if (lat == 0 && act_valid != 4'b0) begin
        lat = i; v = act_valid; c = act_code; w3 = jdo;
      end
    end
    act_ready = 4'b0;
    check("latency", lat, SYNC + 2);
    check("first valid", v, 4'b0100);
    check("first code", c, OCIMEM_A);
    check("first jdo", w3, j);
    check("first issued", issued_cnt, 16'd1);
    check("first valid drop", act_valid, 4'b0);

    for (int k = 0; k < 12; k++)
      run_update($sformatf("vec%0d", k), vecs[k].ir, vecs[k].top, vecs[k].vld, vecs[k].code, 2);

    // Pending action held against ready on other channels; a second update is dropped
    ir_in = 2'b10;
    w3 = rand_sr(3'b100);
    sr = w3;
    act_ready = 4'b1011;
    vs_udr = 1'b1; tick(2); vs_udr = 1'b0; tick(3);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (act_valid != 4'b0100 || act_code != NOACT_BREAK_C || jdo != w3) flag = 1'b0;
      tick(1);
    end
    check("hold stable", flag, 1'b1);
    sr = rand_sr(3'b001);
    vs_udr = 1'b1; tick(2); vs_udr = 1'b0; tick(4);
    check("ovr flag", overrun, 1'b1);
    check("ovr cnt", overrun_cnt, 16'd1);
    check("ovr jdo kept", jdo, w3);
    check("ovr code kept", act_code, NOACT_BREAK_C);
    act_ready = 4'b0100;
    tick(1);
    act_ready = 4'b0;
    check("ovr accept", act_valid, 4'b0);
    clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
    check("clr flag", overrun, 1'b0);
    check("clr cnt", overrun_cnt, 16'd0);

    // Out-of-range select on the 5-channel instance keeps its previous channel
    pulse_uir(3'd5);
    check("bad sel overrun5", overrun5, 1'b1);
    check("bad sel overrun4", overrun, 1'b0);
    ir_in = 2'b11;
    sr = rand_sr(3'b001);
    vs_udr = 1'b1; tick(2); vs_udr = 1'b0; tick(6);
    check("trc valid", act_valid, 4'b0100);
    check("trc valid5", act_valid5, 5'b00100);
    check("trc code5", act_code5, TRACECTRL);
    act_ready = 4'b0100; tick(1); act_ready = 4'b0;
    clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
    ch_sel5 = 3'd2;

    // Reset while an action is pending discards it
    ir_in = 2'b00;
    sr = rand_sr(3'b010);
    vs_udr = 1'b1; tick(2); vs_udr = 1'b0; tick(4);
    check("pre-reset valid", act_valid, 4'b0100);
    reset = 1'b1; tick(1);
    check("reset drops valid", act_valid, 4'b0);
    reset = 1'b0;
    flag = 1'b0;
    act_ready = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (act_valid != 4'b0) flag = 1'b1;
    end
    act_ready = 4'b0;
    check("no late delivery", flag, 1'b0);
    check("reset issued cleared", issued_cnt, 16'd0);

    // Random back-to-back updates against random ready
    rch = $urandom_range(0, 3);
    pulse_uir(3'(rch));
    mon_en = 1'b1;
    fork
      begin
        for (int k = 0; k < NRND; k++) begin
          logic [1:0] ir;
          logic [2:0] top;
          ir = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b10;
          top = {2'($urandom_range(0, (ir == 2'b00) ? 3 : 2)), 1'($urandom_range(0, 1))};
          ir_in = ir;
          sr = rand_sr(top);
          sent.push_back('{model_code(ir, top), sr, 4'(1 << rch)});
          vs_udr = 1'b1; tick(2);
          vs_udr = 1'b0; tick($urandom_range(2, 6));
        end
        tick(8);
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          act_ready = 4'($urandom_range(0, 15));
          tick(1);
        end
      end
    join
    act_ready = 4'b1111;
    for (int i = 0; i < 20 && act_valid != 4'b0; i++) tick(1);
    tick(1);
    mon_en = 1'b0;
    act_ready = 4'b0;
    check("rand drained", act_valid, 4'b0);

    dropped = 0;
    idx = 0;
    foreach (deliv[d]) begin
      while (idx < sent.size() && !(sent[idx].code == deliv[d].code && sent[idx].word == deliv[d].word)) begin
        idx++;
        dropped++;
      end
      check($sformatf("rand match %0d", d), idx < sent.size(), 1'b1);
      if (idx < sent.size()) begin
        check($sformatf("rand channel %0d", d), deliv[d].vld, sent[idx].vld);
        idx++;
      end
    end
    dropped += sent.size() - idx;
    check("rand issued", issued_cnt, 16'(deliv.size()));
    check("rand dropped", overrun_cnt, 16'(dropped));
    check("rand conserve", issued_cnt + overrun_cnt, 16'(NRND));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
